// File: rtl/ppu_fb_writer.sv
// ppu_fb_writer: packs PPU pixels four-per-byte into framebuffer writes
// through a small FIFO towards the framebuffer RAM.
// Optional build macro PPU_FB_PALETTE_EN: map pixel indices through BGP before
// packing. When it is undefined, the raw 2-bit index is stored and BGP is unused.
module ppu_fb_writer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [12:0] FB_BASE    = 13'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PX_IN,
  input  logic        PX_valid,
  input  logic [1:0]  PPU_MODE,
  input  logic [7:0]  BGP,
  output logic        FB_WE,
  output logic [12:0] FB_ADDR,
  output logic [7:0]  FB_DATA,
  input  logic        FB_READY,
  output logic        FRAME_DONE,
  output logic        OVERFLOW
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_SCAN   = 2'd2;
  localparam logic [1:0] MODE_DRAW   = 2'd3;

  localparam logic [7:0] X_END  = 8'd160;
  localparam logic [7:0] Y_LAST = 8'd143;

  logic [7:0]    x;
  logic [7:0]    y;
  logic [7:0]    pack;
  logic [7:0]    pack_nxt;
  logic [1:0]    prev_mode;
  logic [1:0]    shade;
  logic          accept;
  logic          line_evt;
  logic          frame_evt;
  logic          push;
  logic          do_push;
  logic          pop;
  logic          full;
  logic [12:0]   line_off;
  logic [12:0]   push_addr;
  logic [7:0]    push_data;
  logic [20:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          frame_done;
  logic          overflow;

`ifdef PPU_FB_PALETTE_EN
  // Palette lookup: index i selects BGP[2i+1:2i]
  always_comb begin
    shade = BGP[1:0];
    case (PX_IN)
      2'd0: shade = BGP[1:0];
      2'd1: shade = BGP[3:2];
      2'd2: shade = BGP[5:4];
      2'd3: shade = BGP[7:6];
      default: shade = BGP[1:0];
    endcase
  end
`else
  logic unused_bgp;
  assign unused_bgp = ^BGP;

  // Raw index is stored unchanged
  always_comb begin
    shade = PX_IN;
  end
`endif

  // Insert the new shade into its slot; slot 0 starts a fresh, zero-padded byte
  always_comb begin
    pack_nxt = (x[1:0] == 2'd0) ? '0 : pack;
    case (x[1:0])
      2'd0: pack_nxt[7:6] = shade;
      2'd1: pack_nxt[5:4] = shade;
      2'd2: pack_nxt[3:2] = shade;
      2'd3: pack_nxt[1:0] = shade;
      default: pack_nxt = pack;
    endcase
  end

  // Pixel acceptance, mode events and FIFO push/pop decisions
  always_comb begin
    accept    = PX_valid && (PPU_MODE == MODE_DRAW) && (x != X_END);
    line_evt  = (prev_mode == MODE_HBLANK) && (PPU_MODE == MODE_SCAN);
    frame_evt = (PPU_MODE == MODE_VBLANK) && (prev_mode != MODE_VBLANK);
    // A flush coinciding with a completing pixel yields the single completed byte
    push      = (accept && (x[1:0] == 2'd3)) ||
                ((line_evt || frame_evt) && (accept || (x[1:0] != 2'd0)));
    push_data = accept ? pack_nxt : pack;
    line_off  = {y, 5'b0} + {2'b0, y, 3'b0};
    push_addr = FB_BASE + line_off + {7'b0, x[7:2]};
    pop       = (count != '0) && FB_READY;
    full      = (count == FULL_COUNT);
    do_push   = push && (!full || pop);
  end

  // Pixel position, pack register, mode history and frame pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      x          <= '0;
      y          <= '0;
      pack       <= '0;
      prev_mode  <= PPU_MODE;
      frame_done <= 1'b0;
    end else begin
      prev_mode  <= PPU_MODE;
      frame_done <= frame_evt;
      if (accept) pack <= pack_nxt;
      if (frame_evt) begin
        x <= '0;
        y <= '0;
      end else if (line_evt) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 8'd1;
      end else if (accept) begin
        x <= x + 8'd1;
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: {address, packed byte}
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_addr, push_data};
  end

  // Head of FIFO drives the RAM port; zero when idle
  always_comb begin
    FB_WE      = (count != '0);
    FB_ADDR    = FB_WE ? mem[rd_ptr][20:8] : '0;
    FB_DATA    = FB_WE ? mem[rd_ptr][7:0] : '0;
    FRAME_DONE = frame_done;
    OVERFLOW   = overflow;
  end

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Testbench for ppu_fb_writer: directed scenarios plus random traffic checked
// against a queue-based reference model of the framebuffer writer.
module tb_ppu_fb_writer;

  localparam int unsigned DEPTH = 8;
  localparam logic [12:0] BASE  = 13'h0100;
`ifdef PPU_FB_PALETTE_EN
  localparam logic [7:0] EXP_1B_PAL = 8'hE4;
`else
  localparam logic [7:0] EXP_1B_PAL = 8'h1B;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PX_IN;
  logic        PX_valid;
  logic [1:0]  PPU_MODE;
  logic [7:0]  BGP;
  logic        FB_WE;
  logic [12:0] FB_ADDR;
  logic [7:0]  FB_DATA;
  logic        FB_READY;
  logic        FRAME_DONE;
  logic        OVERFLOW;

  always #5 clk = ~clk;

  ppu_fb_writer #(.FIFO_DEPTH(DEPTH), .FB_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .PX_IN(PX_IN), .PX_valid(PX_valid),
    .PPU_MODE(PPU_MODE), .BGP(BGP), .FB_WE(FB_WE), .FB_ADDR(FB_ADDR),
    .FB_DATA(FB_DATA), .FB_READY(FB_READY), .FRAME_DONE(FRAME_DONE),
    .OVERFLOW(OVERFLOW)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          mx, my;
  logic [1:0]  mprev;
  int          shades[$];
  logic [20:0] q[$];
  bit          movf, mdone;

  function automatic logic [1:0] ref_shade(input int idx, input logic [7:0] pal);
    logic [7:0] p;
    p = pal;
`ifndef PPU_FB_PALETTE_EN
    p = 8'hE4;  // identity palette: the raw index is stored
`endif
    return 2'((p >> (2 * idx)) & 8'h03);
  endfunction

  function automatic logic [20:0] make_entry();
    int d, a;
    d = 0;
    for (int i = 0; i < shades.size(); i++) d += shades[i] << (6 - 2 * i);
    a = int'(BASE) + my * 40 + (mx - 1) / 4;
    shades.delete();
    return {13'(a), 8'(d)};
  endfunction

  task automatic cycle(input bit v, input logic [1:0] px, input logic [1:0] mode, input bit rdy);
    bit          pend, popq, full_before;
    logic [20:0] e, head;
    PX_valid = v; PX_IN = px; PPU_MODE = mode; FB_READY = rdy;
    #1;
    check("fb_we", FB_WE, q.size() != 0);
    if (q.size() != 0) begin
      head = q[0];
      check("fb_addr", FB_ADDR, head[20:8]);
      check("fb_data", FB_DATA, head[7:0]);
    end
    check("frame_done", FRAME_DONE, mdone);
    check("overflow", OVERFLOW, movf);
    pend = 0; mdone = 0; e = '0;
    if (v && mode == 2'd3 && mx < 160) begin
      shades.push_back(ref_shade(px, BGP));
      mx++;
      if (shades.size() == 4) begin e = make_entry(); pend = 1; end
    end
    if ((mprev == 2'd0 && mode == 2'd2) || (mprev != 2'd1 && mode == 2'd1)) begin
      if (shades.size() > 0) begin e = make_entry(); pend = 1; end
      mx = 0;
      if (mode == 2'd1) begin my = 0; mdone = 1; end
      else my = (my + 1) % 144;
    end
    mprev = mode;
    full_before = (q.size() == DEPTH);
    popq = (q.size() != 0) && rdy;
    if (popq) void'(q.pop_front());
    if (pend) begin
      if (full_before && !popq) movf = 1;
      else q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0; PX_valid = 1'b0; FB_READY = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_fb_we", FB_WE, 0);
    check("rst_fb_addr", FB_ADDR, 0);
    check("rst_fb_data", FB_DATA, 0);
    check("rst_frame_done", FRAME_DONE, 0);
    check("rst_overflow", OVERFLOW, 0);
    rst = 1'b1;
    mx = 0; my = 0; shades.delete(); q.delete(); movf = 0; mdone = 0;
    mprev = PPU_MODE;
  endtask

  task automatic expect_head(input string tag, input logic [12:0] a, input logic [7:0] d);
    check({tag, "_we"}, FB_WE, 1);
    check({tag, "_addr"}, FB_ADDR, a);
    check({tag, "_data"}, FB_DATA, d);
  endtask

  initial begin
    rst = 1'b0; PX_IN = '0; PX_valid = 1'b0; PPU_MODE = 2'd0; BGP = 8'hE4; FB_READY = 1'b0;
    @(negedge clk);
    do_reset(2);

    // Identity palette, indices 0..3 -> 0x1B one cycle after completion
    BGP = 8'hE4;
    cycle(0, 2'd0, 2'd3, 1);
    for (int i = 0; i < 4; i++) cycle(1, 2'(i), 2'd3, 1);
    expect_head("basic", BASE, 8'h1B);
    cycle(0, 2'd0, 2'd3, 1);

    // Reversed palette
    cycle(0, 2'd0, 2'd1, 1);
    cycle(0, 2'd0, 2'd0, 1);
    cycle(0, 2'd0, 2'd3, 1);
    BGP = 8'h1B;
    for (int i = 0; i < 4; i++) cycle(1, 2'(i), 2'd3, 1);
    expect_head("palette", BASE, EXP_1B_PAL);

    // Partial byte flush on HBLANK->SCAN, next line starts at +40
    BGP = 8'hE4;
    cycle(0, 2'd0, 2'd1, 1);
    cycle(0, 2'd0, 2'd0, 1);
    cycle(0, 2'd0, 2'd3, 1);
    for (int i = 0; i < 4; i++) cycle(1, 2'd1, 2'd3, 1);
    expect_head("full_byte", BASE, 8'h55);
    for (int i = 0; i < 2; i++) cycle(1, 2'd1, 2'd3, 1);
    cycle(0, 2'd0, 2'd0, 1);
    cycle(0, 2'd0, 2'd2, 1);
    expect_head("flush", BASE + 13'd1, 8'h50);
    cycle(0, 2'd0, 2'd2, 1);
    cycle(0, 2'd0, 2'd3, 1);
    for (int i = 0; i < 4; i++) cycle(1, 2'd1, 2'd3, 1);
    expect_head("line1", BASE + 13'd40, 8'h55);

    // Backpressure: 36 bytes into an 8-deep FIFO
    cycle(0, 2'd0, 2'd1, 1);
    cycle(0, 2'd0, 2'd0, 1);
    cycle(0, 2'd0, 2'd3, 1);
    for (int i = 0; i < 144; i++) cycle(1, 2'($urandom_range(0, 3)), 2'd3, 0);
    check("bp_overflow", OVERFLOW, 1);
    check("bp_we", FB_WE, 1);
    check("bp_addr", FB_ADDR, BASE);
    for (int i = 0; i < DEPTH; i++) cycle(0, 2'd0, 2'd3, 1);
    check("bp_drained", FB_WE, 0);

    // Full frame of 144 lines, then VBLANK pulse
    BGP = 8'hE4;
    cycle(0, 2'd0, 2'd1, 1);
    cycle(0, 2'd0, 2'd0, 1);
    for (int l = 0; l < 144; l++) begin
      cycle(0, 2'd0, 2'd3, 1);
      for (int i = 0; i < 5; i++) cycle(1, 2'($urandom_range(0, 3)), 2'd3, 1);
      cycle(0, 2'd0, 2'd0, 1);
      cycle(0, 2'd0, 2'd2, 1);
    end
    cycle(0, 2'd0, 2'd1, 1);
    check("frame_pulse", FRAME_DONE, 1);
    cycle(0, 2'd0, 2'd1, 1);
    check("frame_pulse_end", FRAME_DONE, 0);
    cycle(0, 2'd0, 2'd0, 1);
    cycle(0, 2'd0, 2'd3, 1);
    for (int i = 0; i < 4; i++) cycle(1, 2'd3, 2'd3, 1);
    expect_head("frame_restart", BASE, 8'hFF);

    // Random traffic
    begin
      logic [1:0] m;
      bit rdy;
      m = 2'd3; rdy = 1;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 15) == 0) m = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) rdy = ~rdy;
        if ($urandom_range(0, 63) == 0) BGP = 8'($urandom);
        cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), m, rdy);
      end
    end

    // Long line: x saturates at 160, overrun pixels discarded
    BGP = 8'hE4;
    cycle(0, 2'd0, 2'd1, 1);
    cycle(0, 2'd0, 2'd0, 1);
    cycle(0, 2'd0, 2'd3, 1);
    for (int i = 0; i < 170; i++) cycle(1, 2'($urandom_range(0, 3)), 2'd3, 1);
    cycle(0, 2'd0, 2'd0, 1);
    cycle(0, 2'd0, 2'd2, 1);
    for (int i = 0; i < 4; i++) cycle(0, 2'd0, 2'd2, 1);

    // Reset mid-line with 3 entries pending
    cycle(0, 2'd0, 2'd0, 0);
    cycle(0, 2'd0, 2'd3, 0);
    for (int i = 0; i < 12; i++) cycle(1, 2'($urandom_range(0, 3)), 2'd3, 0);
    check("pre_rst_we", FB_WE, 1);
    do_reset(1);
    for (int i = 0; i < 5; i++) cycle(0, 2'd0, 2'd3, 1);
    check("post_rst_overflow", OVERFLOW, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppu_fb_writer.md
PPU_FB_WRITER -- requirements
Module: ppu_fb_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning number of pending framebuffer write entries (power of two, 2..16).
REQ-002 SHALL have parameter FB_BASE, default 13'h0000, meaning framebuffer byte address of pixel (0,0).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port PX_IN  input  2  pixel colour index from PPU fifo.
REQ-006 SHALL have port PX_valid  input  1  PX_IN qualifier, one pixel per cycle when high.
REQ-007 SHALL have port PPU_MODE  input  2  PPU mode: 0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW.
REQ-008 SHALL have port BGP  input  8  background palette register value.
REQ-009 SHALL have port FB_WE  output  1  write request to framebuffer RAM.
REQ-010 SHALL have port FB_ADDR  output  13  framebuffer byte address.
REQ-011 SHALL have port FB_DATA  output  8  four packed 2-bit shades.
REQ-012 SHALL have port FB_READY  input  1  RAM accepts write when FB_WE && FB_READY.
REQ-013 SHALL have port FRAME_DONE  output  1  one-cycle pulse at frame end.
REQ-014 SHALL have port OVERFLOW  output  1  sticky flag: a packed byte was dropped.

Function
REQ-015 SHALL accept a pixel only when PX_valid==1 and PPU_MODE==3; otherwise PX_IN ignored.
REQ-016 SHALL map accepted index i to shade BGP[2i+1:2i] in the acceptance cycle.
REQ-017 SHALL pack shades MSB-first: pixel x%4==0 in bits [7:6], x%4==3 in bits [1:0].
REQ-018 SHALL keep x counter 0..160 and y counter 0..143; x increments per accepted pixel, saturates at 160; pixels accepted at x==160 dropped silently.
REQ-019 SHALL push {FB_BASE + y*40 + x/4, byte} into FIFO in the cycle the 4th pixel of a byte is accepted.
REQ-020 SHALL, on PPU_MODE transition 0->2, flush any partial byte (unfilled slots 2'b00) to FIFO, clear x, increment y (wrap 143->0).
REQ-021 SHALL, on any transition into PPU_MODE==1, flush partial byte, clear x and y, pulse FRAME_DONE for exactly one cycle.
REQ-022 SHALL drive FB_WE = FIFO not empty; FB_ADDR/FB_DATA = FIFO head, stable while FB_WE && !FB_READY.
REQ-023 SHALL pop head in cycle FB_WE && FB_READY.
REQ-024 SHALL latency: byte completed in cycle N with FIFO empty appears on FB_WE in cycle N+1.
REQ-025 SHALL, on push when full without simultaneous pop, drop new entry and set OVERFLOW=1 until reset; push at full with pop in same cycle succeeds.
REQ-026 SHALL treat flush and 4th-pixel completion in same cycle as one push (completed byte), no duplicate entry.
REQ-027 SHALL never produce FB_ADDR outside FB_BASE..FB_BASE+5759.

Reset
REQ-028 SHALL, while rst==0 at clock edge, clear x, y, pack register, FIFO pointers; outputs FB_WE=0, FB_ADDR=0, FB_DATA=0, FRAME_DONE=0, OVERFLOW=0.
REQ-029 SHALL discard pending FIFO entries on reset mid-frame; FB_WE low first cycle after release.

Configuration
REQ-030 SHALL, with macro PPU_FB_PALETTE_EN defined, apply BGP mapping per REQ-016.
REQ-031 SHALL, without PPU_FB_PALETTE_EN, store raw PX_IN index; BGP ignored, all other behaviour identical.

Verification
REQ-032 SHALL cover: BGP=8'hE4, DRAW, indices 0,1,2,3, FB_READY=1 -> FB_WE one cycle later, FB_ADDR=0, FB_DATA=8'h1B.
REQ-033 SHALL cover: BGP=8'h1B, same pixels -> FB_DATA=8'hE4 (macro on); 8'h1B (macro off).
REQ-034 SHALL cover: 6 pixels of 1 then mode 0->2 -> bytes 8'h55 @0 and 8'h50 @1; next line first byte @40.
REQ-035 SHALL cover: FB_READY=0, 36 bytes pushed with FIFO_DEPTH=8 -> 8 held, OVERFLOW=1, head addr/data unchanged until FB_READY=1.
REQ-036 SHALL cover: 144 lines then mode ->1 -> FRAME_DONE single pulse, next DRAW pixel written @FB_BASE.
REQ-037 SHALL cover: rst=0 mid-line with 3 FIFO entries -> FB_WE=0 after release, no stale writes, OVERFLOW=0.
